// File: rtl/serial_clk_receiver.sv
// serial_clk_receiver: synchronises an idle-high serial clock/data pair into i_clk and assembles
// MSB-first words. Define SERIAL_RX_PARITY_EN to add a trailing even-parity bit and o_parity_err.
module serial_clk_receiver #(
  parameter int          DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16'd10416,
  parameter int          TIMEOUT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_sclk,
  input  logic                  i_sdata,
  input  logic                  i_clear_stb,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_busy,
  output logic                  o_frame_err
`ifdef SERIAL_RX_PARITY_EN
  ,
  output logic                  o_parity_err
`endif
);

  // Handshake: o_data_valid and o_frame_err are one-cycle strobes with no back-pressure;
  // o_data is held from one o_data_valid until the next and is never cleared by a timeout.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  // Without parity the final bit goes straight to o_data, so one bit less of storage is needed.
`ifdef SERIAL_RX_PARITY_EN
  localparam int SH_W = DATA_WIDTH;
`else
  localparam int SH_W = DATA_WIDTH - 1;
`endif

  state_t                  state_q, state_d;
  logic                    sclk_s1_q, sclk_s1_d;
  logic                    sclk_s2_q, sclk_s2_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic                    sdata_s1_q, sdata_s1_d;
  logic                    sdata_s2_q, sdata_s2_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic [SH_W-1:0]         shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                    perr_q, perr_d;
`endif
  logic                    rise;

  assign rise = sclk_s2_q & ~sclk_prev_q;

  always_comb begin
    sclk_s1_d   = i_sclk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    sdata_s1_d  = i_sdata;
    sdata_s2_d  = sdata_s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    perr_d      = 1'b0;
`endif
    if (i_clear_stb) begin
      // Clear outranks everything but reset; a coincident rise is dropped.
      state_d = ST_IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmo_d = '0;
          if (rise) begin
            shift_d = SH_W'({shift_q, sdata_s2_q});
            cnt_d   = CNT_W'(1);
            state_d = ST_RECV;
          end
        end
        ST_RECV: begin
          if (rise) begin
            tmo_d = '0;
            if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              shift_d = SH_W'({shift_q, sdata_s2_q});
              cnt_d   = CNT_W'(DATA_WIDTH);
              state_d = ST_PARITY;
`else
              data_d  = {shift_q, sdata_s2_q};
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
`endif
            end else begin
              shift_d = SH_W'({shift_q, sdata_s2_q});
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          if (rise) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = ^{shift_q, sdata_s2_q};
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = ST_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            tmo_d   = '0;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TIMEOUT_WIDTH'(1);
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      sclk_s1_q   <= 1'b1;
      sclk_s2_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
      sdata_s1_q  <= 1'b1;
      sdata_s2_q  <= 1'b1;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      sdata_s1_q  <= sdata_s1_d;
      sdata_s2_q  <= sdata_s2_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_err  = err_q;
`ifdef SERIAL_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_clk_receiver.sv
// tb_serial_clk_receiver: drives serial frames on the pins and checks words, strobes and timing
// against a model where a word appears 3 i_clk cycles after its final pin rise.
module tb_serial_clk_receiver;
  localparam int W   = 8;
  localparam int TMO = 50;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk  = 1'b1;
  logic         sdata = 1'b1;
  logic         clear = 1'b0;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_busy;
  logic         o_err;
`ifdef SERIAL_RX_PARITY_EN
  logic         o_perr;
`endif

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int last_rise = 0;

  // Scoreboard: expected words with their arrival cycle, and expected timeout cycles.
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         exp_perr_q[$];
  int           exp_err_q[$];
  logic         pend   = 1'b0;
  logic [W-1:0] pend_w = '0;
  logic         pend_p = 1'b0;
  logic [W-1:0] mon_d;
  int           mon_c;

  serial_clk_receiver #(
    .DATA_WIDTH    (W),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_WIDTH (16)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_sclk      (sclk),
    .i_sdata     (sdata),
    .i_clear_stb (clear),
    .o_data      (o_data),
    .o_data_valid(o_valid),
    .o_busy      (o_busy),
    .o_frame_err (o_err)
`ifdef SERIAL_RX_PARITY_EN
    ,
    .o_parity_err(o_perr)
`endif
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid || o_err) begin
        checks++;
        if (o_valid && o_err) begin
          failures++;
          $display("FAIL strobe_overlap valid=%b err=%b cyc=%0d", o_valid, o_err, cyc);
        end
      end
      if (o_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid got data=%h cyc=%0d exp none", o_data, cyc);
        end else begin
          mon_d = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          checks++;
          if (o_data !== mon_d) begin
            failures++;
            $display("FAIL word_data got=%h exp=%h", o_data, mon_d);
          end
          checks++;
          if (cyc !== mon_c) begin
            failures++;
            $display("FAIL word_latency got cyc=%0d exp cyc=%0d", cyc, mon_c);
          end
          checks++;
          if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_valid got=%b exp=0", o_busy);
          end
`ifdef SERIAL_RX_PARITY_EN
          checks++;
          if (o_perr !== exp_perr_q[0]) begin
            failures++;
            $display("FAIL parity_err got=%b exp=%b", o_perr, exp_perr_q[0]);
          end
          void'(exp_perr_q.pop_front());
`endif
        end
      end
      if (o_err) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame_err cyc=%0d exp none", cyc);
        end else begin
          mon_c = exp_err_q.pop_front();
          checks++;
          if (cyc !== mon_c) begin
            failures++;
            $display("FAIL frame_err_time got cyc=%0d exp cyc=%0d", cyc, mon_c);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(input logic [W-1:0] w, input logic p);
    pend   = 1'b1;
    pend_w = w;
    pend_p = p;
  endtask

  task automatic send_bit(input logic b, input int lo, input int hi);
    sclk  = 1'b0;
    sdata = b;
    wait_cyc(lo);
    sclk      = 1'b1;
    last_rise = cyc;
    if (pend) begin
      exp_q.push_back(pend_w);
      exp_cyc_q.push_back(cyc + 3);
`ifdef SERIAL_RX_PARITY_EN
      exp_perr_q.push_back(pend_p);
`endif
      pend = 1'b0;
    end
    wait_cyc(hi);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int lo, input int hi);
    for (int i = W - 1; i >= 0; i--) begin
`ifndef SERIAL_RX_PARITY_EN
      if (i == 0) arm(w, 1'b0);
`endif
      send_bit(w[i], lo, hi);
    end
`ifdef SERIAL_RX_PARITY_EN
    arm(w, 1'b0);
    send_bit(^w, lo, hi);
`endif
  endtask

  // Tests
  task automatic test_reset;
    rst_n = 1'b0;
    wait_cyc(5);
    rst_n = 1'b1;
    checks++;
    if (o_data !== '0 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got data=%h busy=%b valid=%b err=%b exp all 0",
               o_data, o_busy, o_valid, o_err);
    end
    wait_cyc(100);
    checks++;
    if (o_busy !== 1'b0 || o_data !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b data=%h exp 0/00", o_busy, o_data);
    end
  endtask

  task automatic test_single;
    send_frame(8'hA5, 10, 10);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_delivered got pending=%0d exp 0", exp_q.size());
    end
    checks++;
    if (o_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_hold got=%h exp=a5", o_data);
    end
  endtask

  task automatic test_timeout;
    send_bit(1'b0, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b1, 10, 10);
    exp_err_q.push_back(last_rise + 3 + TMO);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid_frame got=%b exp=1", o_busy);
    end
    wait_cyc(TMO + 10);
    checks++;
    if (exp_err_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_seen got pending=%0d exp 0", exp_err_q.size());
    end
    checks++;
    if (o_data !== 8'hA5 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_keeps_data got data=%h busy=%b exp a5/0", o_data, o_busy);
    end
    send_frame(8'h3C, 10, 10);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'h3C) begin
      failures++;
      $display("FAIL after_timeout got data=%h pending=%0d exp 3c/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_clear;
    send_bit(1'b1, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b0, 10, 10);
    send_bit(1'b1, 10, 10);
    send_bit(1'b1, 10, 10);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_data !== 8'h3C) begin
      failures++;
      $display("FAIL clear_mid_frame got busy=%b data=%h exp 0/3c", o_busy, o_data);
    end
    send_frame(8'h0F, 10, 10);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'h0F) begin
      failures++;
      $display("FAIL after_clear got data=%h pending=%0d exp 0f/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_clear_rise;
    sclk = 1'b0;
    wait_cyc(3);
    sclk = 1'b1;
    wait_cyc(2);
    clear = 1'b1;
    wait_cyc(1);
    clear = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_drops_rise got busy=%b exp=0", o_busy);
    end
    wait_cyc(5);
    send_frame(8'h5A, 4, 4);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'h5A) begin
      failures++;
      $display("FAIL after_clear_rise got data=%h pending=%0d exp 5a/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_mid_reset;
    send_bit(1'b1, 5, 5);
    send_bit(1'b0, 5, 5);
    send_bit(1'b1, 5, 5);
    send_bit(1'b1, 5, 5);
    rst_n = 1'b0;
    wait_cyc(2);
    checks++;
    if (o_data !== '0 || o_busy !== 1'b0 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got data=%h busy=%b valid=%b err=%b exp all 0",
               o_data, o_busy, o_valid, o_err);
    end
    rst_n = 1'b1;
    wait_cyc(3);
    send_frame(8'h96, 5, 5);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'h96) begin
      failures++;
      $display("FAIL after_mid_reset got data=%h pending=%0d exp 96/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    send_frame(8'hFF, 3, 3);
    send_frame(8'h00, 3, 3);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'h00) begin
      failures++;
      $display("FAIL back_to_back got data=%h pending=%0d exp 00/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_rise_at_timeout;
    // Rises exactly TMO cycles apart land on the terminal count; the bit must win.
    send_frame(8'hC3, TMO / 2, TMO - TMO / 2);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'hC3) begin
      failures++;
      $display("FAIL rise_at_timeout got data=%h pending=%0d exp c3/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_random;
    logic [W-1:0] w;
    for (int f = 0; f < 30; f++) begin
      w = W'($urandom_range(0, (1 << W) - 1));
      send_frame(w, $urandom_range(1, 6), $urandom_range(1, 6));
      wait_cyc($urandom_range(0, 8));
    end
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== w) begin
      failures++;
      $display("FAIL random_frames got data=%h pending=%0d exp %h/0", o_data, exp_q.size(), w);
    end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity;
    logic [W-1:0] w;
    w = 8'h81;
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], 4, 4);
    arm(w, 1'b1);
    send_bit(1'b1, 4, 4);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], 4, 4);
    arm(w, 1'b0);
    send_bit(1'b0, 4, 4);
    wait_cyc(10);
    checks++;
    if (exp_q.size() != 0 || o_data !== 8'h81) begin
      failures++;
      $display("FAIL parity_frames got data=%h pending=%0d exp 81/0", o_data, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_clear();
    test_clear_rise();
    test_mid_reset();
    test_back_to_back();
    test_rise_at_timeout();
    test_random();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    wait_cyc(5);
    checks++;
    if (exp_q.size() != 0 || exp_err_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain got words=%0d errs=%0d exp 0/0", exp_q.size(), exp_err_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
